// File: rtl/div_seq.sv
// Multicycle signed divider for DIV (MIPS semantics).
// The quotient truncates toward zero and the remainder takes the dividend's sign.
// It uses one restoring-division step per cycle, MSB first, on operand magnitudes.
// The signs are applied in a final cycle.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset; clears all state and outputs
//   start     one-cycle request, honoured only when idle
//   dividend  signed numerator (rs), sampled with start
//   divisor   signed denominator (rt), sampled with start
//   busy      high while an operation is in flight
//   done      one-cycle pulse; hi/lo valid from this cycle
//   div_zero  one-cycle pulse; the divisor was zero at start
//   hi        remainder
//   lo        quotient
module div_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = $clog2(WIDTH) + 1;

    typedef enum logic [2:0] {StIdle, StCalc, StSign, StDone, StDz} state_e;

    state_e            state_q, state_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  rem_q, rem_d;
    logic [WIDTH-1:0]  quo_q, quo_d;
    logic [WIDTH:0]    dvsr_q, dvsr_d;
    logic              neg_quo_q, neg_quo_d;
    logic              neg_rem_q, neg_rem_d;
    logic [WIDTH-1:0]  hi_q, hi_d;
    logic [WIDTH-1:0]  lo_q, lo_d;
    logic              busy_q, done_q, div_zero_q;

    // Magnitudes at WIDTH+1 bits so the most negative operand is represented exactly.
    logic [WIDTH:0]    dvnd_ext, dvsr_ext, dvnd_abs, dvsr_abs;
    logic [WIDTH:0]    rem_shift;
    logic [WIDTH+1:0]  diff;

    always_comb begin
        dvnd_ext = {dividend[WIDTH-1], dividend};
        dvsr_ext = {divisor[WIDTH-1], divisor};
        dvnd_abs = dividend[WIDTH-1] ? -dvnd_ext : dvnd_ext;
        dvsr_abs = divisor[WIDTH-1] ? -dvsr_ext : dvsr_ext;
        rem_shift = {rem_q, quo_q[WIDTH-1]};
        diff = {1'b0, rem_shift} - {1'b0, dvsr_q};
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dvsr_d    = dvsr_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            StIdle: begin
                if (start) begin
                    if (divisor == '0) begin
                        state_d = StDz;
                    end else begin
                        // |dividend| never exceeds 2^(WIDTH-1), so it fits in WIDTH bits.
                        quo_d     = WIDTH'(dvnd_abs);
                        dvsr_d    = dvsr_abs;
                        rem_d     = '0;
                        neg_quo_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        neg_rem_d = dividend[WIDTH-1];
                        cnt_d     = '0;
                        state_d   = StCalc;
                    end
                end
            end
            StCalc: begin
                // A negative trial difference means restore the shifted remainder.
                // The kept remainder is always below |divisor| <= 2^(WIDTH-1).
                rem_d = diff[WIDTH+1] ? WIDTH'(rem_shift) : WIDTH'(diff);
                quo_d = {quo_q[WIDTH-2:0], ~diff[WIDTH+1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    state_d = StSign;
                end
            end
            StSign: begin
                hi_d    = neg_rem_q ? -rem_q : rem_q;
                lo_d    = neg_quo_q ? -quo_q : quo_q;
                state_d = StDone;
            end
            StDone:  state_d = StIdle;
            StDz:    state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvsr_q     <= '0;
            neg_quo_q  <= 1'b0;
            neg_rem_q  <= 1'b0;
            hi_q       <= '0;
            lo_q       <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
            dvsr_q     <= dvsr_d;
            neg_quo_q  <= neg_quo_d;
            neg_rem_q  <= neg_rem_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            // Status flags are registered from the next state so they line up with it.
            busy_q     <= (state_d != StIdle);
            done_q     <= (state_d == StDone);
            div_zero_q <= (state_d == StDz);
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;

endmodule

// File: tb/tb_div_seq.sv
module tb_div_seq;

    logic        clk;
    logic        reset;
    logic        start;
    logic [31:0] dividend;
    logic [31:0] divisor;
    logic        busy;
    logic        done;
    logic        div_zero;
    logic [31:0] hi;
    logic [31:0] lo;

    int total = 0;
    int bad   = 0;

    div_seq #(.WIDTH(32)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .dividend (dividend),
        .divisor  (divisor),
        .busy     (busy),
        .done     (done),
        .div_zero (div_zero),
        .hi       (hi),
        .lo       (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp_lo;
        logic [31:0] exp_hi;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called at a negedge with the DUT idle. Returns at the negedge of the first idle cycle
    // after done, so a following call issues start back-to-back.
    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_lo, input logic [31:0] exp_hi,
                           input int poke_at);
        int n;
        int done_at;
        int busy_cnt;
        int dz_seen;
        logic [31:0] got_lo;
        logic [31:0] got_hi;
        n = 0;
        done_at = -1;
        busy_cnt = 0;
        dz_seen = 0;
        got_lo = 'x;
        got_hi = 'x;
        dividend = a;
        divisor  = b;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        // Operands must have been captured; scramble them.
        dividend = $urandom;
        divisor  = $urandom | 32'h1;
        while (n < 60) begin
            if (busy) busy_cnt++;
            if (div_zero) dz_seen = 1;
            if (done && done_at < 0) begin
                done_at = n;
                got_lo = lo;
                got_hi = hi;
            end
            if (done_at >= 0 && n == done_at + 1) break;
            if (n == poke_at) begin
                start    = 1'b1;
                dividend = 32'd5;
                divisor  = 32'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
        check({name, " latency"}, 32'(done_at), 32'd33);
        check({name, " lo"}, got_lo, exp_lo);
        check({name, " hi"}, got_hi, exp_hi);
        check({name, " busy cycles"}, 32'(busy_cnt), 32'd34);
        check({name, " div_zero"}, 32'(dz_seen), 32'd0);
        check({name, " done width"}, {31'd0, done}, 32'd0);
    endtask

    initial begin
        int saw;
        vecs[0]  = '{32'd7,         32'd2,         32'd3,         32'd1};
        vecs[1]  = '{32'hFFFFFFF9,  32'd2,         32'hFFFFFFFD,  32'hFFFFFFFF};
        vecs[2]  = '{32'd7,         32'hFFFFFFFE,  32'hFFFFFFFD,  32'd1};
        vecs[3]  = '{32'hFFFFFFF9,  32'hFFFFFFFE,  32'd3,         32'hFFFFFFFF};
        vecs[4]  = '{32'h80000000,  32'hFFFFFFFF,  32'h80000000,  32'd0};
        vecs[5]  = '{32'd1000,      32'd7,         32'd142,       32'd6};
        vecs[6]  = '{32'hFFFFFFFF,  32'd1,         32'hFFFFFFFF,  32'd0};
        vecs[7]  = '{32'd0,         32'd5,         32'd0,         32'd0};
        vecs[8]  = '{32'h80000000,  32'd1,         32'h80000000,  32'd0};
        vecs[9]  = '{32'h7FFFFFFF,  32'h80000000,  32'd0,         32'h7FFFFFFF};
        vecs[10] = '{32'h80000000,  32'h80000000,  32'd1,         32'd0};
        vecs[11] = '{32'h80000000,  32'd7,         32'hEDB6DB6E,  32'hFFFFFFFE};
        vecs[12] = '{32'd3,         32'd7,         32'd0,         32'd3};

        // Reset with start held: reset must win.
        reset = 1'b1;
        start = 1'b1;
        dividend = 32'd7;
        divisor = 32'd2;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        start = 1'b0;
        check("reset busy", {31'd0, busy}, 32'd0);
        check("reset done", {31'd0, done}, 32'd0);
        check("reset div_zero", {31'd0, div_zero}, 32'd0);
        check("reset lo", lo, 32'd0);
        check("reset hi", hi, 32'd0);
        @(negedge clk);
        check("post-reset idle", {31'd0, busy}, 32'd0);

        for (int i = 0; i < 13; i++) begin
            run_div($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].exp_lo,
                    vecs[i].exp_hi, -1);
        end

        // Start re-pulsed while busy must be ignored.
        run_div("ignore start", 32'd1000, 32'd7, 32'd142, 32'd6, 10);

        // Divide by zero: one div_zero pulse, no done, result registers untouched.
        dividend = 32'd100;
        divisor  = 32'd0;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("dz pulse", {31'd0, div_zero}, 32'd1);
        check("dz busy", {31'd0, busy}, 32'd1);
        check("dz no done", {31'd0, done}, 32'd0);
        @(negedge clk);
        check("dz pulse end", {31'd0, div_zero}, 32'd0);
        check("dz busy end", {31'd0, busy}, 32'd0);
        saw = 0;
        repeat (6) begin
            @(negedge clk);
            if (done || div_zero || busy) saw = 1;
        end
        check("dz quiet", 32'(saw), 32'd0);
        check("dz lo kept", lo, 32'd142);
        check("dz hi kept", hi, 32'd6);

        // Back-to-back: second start in the first idle cycle after done.
        run_div("b2b first", 32'd7, 32'd2, 32'd3, 32'd1, -1);
        run_div("b2b second", 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, -1);

        // Reset in the middle of an operation aborts it.
        dividend = 32'd9;
        divisor  = 32'd3;
        start    = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (20) @(negedge clk);
        check("abort busy before", {31'd0, busy}, 32'd1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("abort busy", {31'd0, busy}, 32'd0);
        check("abort lo", lo, 32'd0);
        check("abort hi", hi, 32'd0);
        check("abort done", {31'd0, done}, 32'd0);
        saw = 0;
        repeat (40) begin
            @(negedge clk);
            if (done || div_zero || busy) saw = 1;
        end
        check("abort quiet", 32'(saw), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/div_seq.md
Name: div_seq

Overview:
- Multicycle signed divider for DIV. Produces quotient and remainder for the HI/LO registers.
- Sits upstream of the mult/div result mux that feeds HI and LO. Operands come from the ALU A/B source muxes.
- The control unit starts it with a pulse and waits for done. It raises a divide-by-zero flag for the exception path.

Parameters:
WIDTH, 32, operand/result width; internal iteration counter is clog2(WIDTH)+1 bits

Ports:
clk  input  1  rising-edge clock
reset  input  1  synchronous, active-high; clears all state and outputs
start  input  1  one-cycle request; sampled only in IDLE
dividend  input  WIDTH  signed numerator (rs); sampled with start
divisor  input  WIDTH  signed denominator (rt); sampled with start
busy  output  1  high while not in IDLE
done  output  1  one-cycle pulse; hi/lo valid and stable from this cycle
div_zero  output  1  one-cycle pulse; divisor was zero at start
hi  output  WIDTH  remainder (HI)
lo  output  WIDTH  quotient (LO)

Behaviour:
- Reset (synchronous, active-high, one clk, clk/reset as the codebase names them): state=IDLE, hi=0, lo=0, done=0, div_zero=0, busy=0, counter=0. Reset wins over start and aborts an operation in progress; no done or div_zero pulse follows.
- States: IDLE, CALC, SIGN, DONE, DZ.
- IDLE, start=1, divisor==0: go to DZ.
- DZ: div_zero=1 for exactly one cycle. hi/lo unchanged, no done. Next state IDLE.
- IDLE, start=1, divisor!=0:
  - latch |dividend| and |divisor| using two's-complement abs, computed at WIDTH+1 bits so -2^31 is exact.
  - latch sign_q = dividend[MSB]^divisor[MSB] and sign_r = dividend[MSB].
  - clear partial remainder, counter=0, go to CALC.
- CALC: one restoring-division step per cycle, MSB first.
  - shift {rem,quo} left by 1, trial-subtract |divisor| from rem.
  - if non-negative, keep the difference and set quo LSB=1; else restore and set quo LSB=0.
  - after WIDTH steps go to SIGN.
- SIGN: hi = sign_r ? -rem : rem; lo = sign_q ? -quo : quo, both truncated to WIDTH. Go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Latency: if start is sampled at edge k, done is high in the cycle after edge k+WIDTH+1 (k+33 for WIDTH=32). busy is high from edge k until the edge after done.
- Arithmetic follows MIPS: quotient truncates toward zero; remainder takes the dividend's sign; |hi| < |divisor|.
- Overflow -2^31 / -1: lo=0x80000000 (wrapped), hi=0. No flag raised.
- start while busy is ignored; operands are not re-sampled, so the caller may change them after the start cycle.
- hi/lo hold the last completed result until the next SIGN state or reset.
- done and div_zero are never high in the same cycle.
- Fully synchronous, single clock domain, no latches; all outputs are registered.

Test Plan:
- reset, then start with dividend=7, divisor=2 -> busy=1 for 34 cycles; done pulse 33 cycles after the start edge with lo=3, hi=1.
- dividend=-7 (0xFFFFFFF9), divisor=2 -> lo=0xFFFFFFFD (-3), hi=0xFFFFFFFF (-1). Also 7/-2 -> lo=-3, hi=1.
- dividend=100, divisor=0 -> div_zero=1 for one cycle after the start edge, done never asserted, hi/lo keep the previous result, busy back to 0 after 2 cycles.
- dividend=0x80000000, divisor=0xFFFFFFFF -> lo=0x80000000, hi=0, done pulse, div_zero=0.
- start 1000/7, re-pulse start with 5/5 at cycle 10 -> second start ignored, result lo=142, hi=6. Then assert reset at cycle 20 of a new 9/3 op -> outputs 0, busy=0, no done.
- back-to-back: start 0xFFFFFFFF/1 on the cycle after done of the previous op -> accepted; lo=0xFFFFFFFF, hi=0.
